// File: rtl/gtx_link_ctrl.sv
// GTX 8b/10b link bring-up controller and TX/RX scheduler: reset sequencing, K28.5 training, error-window retrain.
// Optional clock-correction idle insertion is compiled in with `define GTX_LINK_CTRL_CLK_COR_EN.
module gtx_link_ctrl #(
    parameter logic [15:0] IDLE_WORD   = 16'h50BC,
    parameter logic [1:0]  IDLE_CTRL   = 2'b01,
    parameter int          RST_CYC     = 16,
    parameter int          ALIGN_CNT   = 64,
    parameter int          TIMEOUT_CYC = 65536,
    parameter int          ERR_WINDOW  = 1024,
    parameter int          ERR_LIMIT   = 15
`ifdef GTX_LINK_CTRL_CLK_COR_EN
    ,
    parameter int          CC_PERIOD   = 5000
`endif
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        tx_reset_done_i,
    input  logic        rx_reset_done_i,
    output logic        gt_reset_o,
    input  logic [15:0] rx_data_i,
    input  logic [1:0]  rx_ctrl_i,
    input  logic [1:0]  rx_disp_err_i,
    input  logic [1:0]  rx_not_in_table_i,
    input  logic [15:0] tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic [15:0] tx_data_o,
    output logic [1:0]  tx_ctrl_o,
    output logic [15:0] rx_data_o,
    output logic        rx_valid_o,
    output logic        link_up_o,
    output logic [1:0]  state_o,
    output logic [7:0]  retrain_cnt_o
);

    localparam logic [1:0] S_RESET     = 2'd0;
    localparam logic [1:0] S_WAIT_DONE = 2'd1;
    localparam logic [1:0] S_ALIGN     = 2'd2;
    localparam logic [1:0] S_LINK_UP   = 2'd3;

    localparam int RST_W = $clog2(RST_CYC);
    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    localparam int RUN_W = $clog2(ALIGN_CNT);
    localparam int WIN_W = $clog2(ERR_WINDOW);
    localparam int ERR_W = $clog2(ERR_LIMIT);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [1:0]       state, state_nxt;
    logic [RST_W-1:0] rst_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [RUN_W-1:0] run_cnt;
    logic [WIN_W-1:0] win_cnt;
    logic [ERR_W-1:0] err_cnt, err_cnt_nxt;
    logic [7:0]       retrain_cnt;
    logic             err_evt, idle_ok, rx_ok, tmo_hit, win_wrap;
    logic             retrain, up_stay, accept, cc_slot;

    assign err_evt  = (|rx_disp_err_i) | (|rx_not_in_table_i);
    assign idle_ok  = !err_evt && (rx_data_i == IDLE_WORD) && (rx_ctrl_i == IDLE_CTRL);
    assign rx_ok    = !err_evt && (rx_ctrl_i == 2'b00);
    assign tmo_hit  = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
    assign win_wrap = (win_cnt == WIN_W'(ERR_WINDOW - 1));
    // An error on the wrap cycle opens the new window rather than closing the old one.
    assign err_cnt_nxt = win_wrap ? ERR_W'(err_evt) : err_cnt + ERR_W'(err_evt);

    always_comb begin
        state_nxt = state;
        retrain   = 1'b0;
        case (state)
            S_RESET: begin
                if (rst_cnt == RST_W'(RST_CYC - 1)) state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (tx_reset_done_i && rx_reset_done_i) begin
                    state_nxt = S_ALIGN;
                end else if (tmo_hit) begin
                    state_nxt = S_RESET;
                    retrain   = 1'b1;
                end
            end
            S_ALIGN: begin
                if (idle_ok && run_cnt == RUN_W'(ALIGN_CNT - 1)) begin
                    state_nxt = S_LINK_UP;
                end else if (tmo_hit) begin
                    state_nxt = S_RESET;
                    retrain   = 1'b1;
                end
            end
            default: begin
                if (!tx_reset_done_i || !rx_reset_done_i || err_cnt_nxt == ERR_W'(ERR_LIMIT)) begin
                    state_nxt = S_RESET;
                    retrain   = 1'b1;
                end
            end
        endcase
    end

    assign up_stay = (state == S_LINK_UP) && (state_nxt == S_LINK_UP);

`ifdef GTX_LINK_CTRL_CLK_COR_EN
    localparam int CC_W = $clog2(CC_PERIOD);
    logic [CC_W-1:0] cc_cnt;

    assign cc_slot = (cc_cnt == CC_W'(CC_PERIOD - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || !up_stay) cc_cnt <= '0;
        else                   cc_cnt <= cc_slot ? '0 : cc_cnt + 1'b1;
    end
`else
    assign cc_slot = 1'b0;
`endif

    assign gt_reset_o    = (state == S_RESET);
    assign link_up_o     = (state == S_LINK_UP);
    assign tx_ready_o    = (state == S_LINK_UP) && !cc_slot;
    assign accept        = tx_valid_i && tx_ready_o;
    assign state_o       = state;
    assign retrain_cnt_o = retrain_cnt;

    // Stage p0 -> p1: state, timers and the registered TX/RX word outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_RESET;
            rst_cnt     <= '0;
            tmo_cnt     <= '0;
            run_cnt     <= '0;
            win_cnt     <= '0;
            err_cnt     <= '0;
            retrain_cnt <= '0;
            tx_data_o   <= IDLE_WORD;
            tx_ctrl_o   <= IDLE_CTRL;
            rx_data_o   <= '0;
            rx_valid_o  <= 1'b0;
        end else begin
            state   <= state_nxt;
            rst_cnt <= (state == S_RESET && state_nxt == S_RESET) ? rst_cnt + 1'b1 : '0;
            tmo_cnt <= ((state == S_WAIT_DONE || state == S_ALIGN) && state_nxt == state)
                       ? tmo_cnt + 1'b1 : '0;
            run_cnt <= (state == S_ALIGN && state_nxt == S_ALIGN && idle_ok) ? run_cnt + 1'b1 : '0;
            win_cnt <= (up_stay && !win_wrap) ? win_cnt + 1'b1 : '0;
            err_cnt <= up_stay ? err_cnt_nxt : '0;
            if (retrain) retrain_cnt <= sat_inc8(retrain_cnt);
            tx_data_o  <= accept ? tx_data_i : IDLE_WORD;
            tx_ctrl_o  <= accept ? 2'b00 : IDLE_CTRL;
            if (up_stay && rx_ok) rx_data_o <= rx_data_i;
            rx_valid_o <= up_stay && rx_ok;
        end
    end

endmodule

// File: tb/tb_gtx_link_ctrl.sv
// Directed bench for gtx_link_ctrl: bring-up, data path, error window, run restart, timeout, CC slots.
module tb_gtx_link_ctrl;

`ifdef GTX_LINK_CTRL_CLK_COR_EN
    localparam bit CC_EN = 1'b1;
`else
    localparam bit CC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i, tx_reset_done_i, rx_reset_done_i, gt_reset_o;
    logic [15:0] rx_data_i, tx_data_i, tx_data_o, rx_data_o;
    logic [1:0]  rx_ctrl_i, rx_disp_err_i, rx_not_in_table_i, tx_ctrl_o, state_o;
    logic        tx_valid_i, tx_ready_o, rx_valid_o, link_up_o;
    logic [7:0]  retrain_cnt_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Serial loopback: the receiver sees exactly what was transmitted.
    assign rx_data_i = tx_data_o;
    assign rx_ctrl_i = tx_ctrl_o;

    gtx_link_ctrl dut (
        .clk_i(clk), .rst_i(rst_i),
        .tx_reset_done_i(tx_reset_done_i), .rx_reset_done_i(rx_reset_done_i),
        .gt_reset_o(gt_reset_o),
        .rx_data_i(rx_data_i), .rx_ctrl_i(rx_ctrl_i),
        .rx_disp_err_i(rx_disp_err_i), .rx_not_in_table_i(rx_not_in_table_i),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .tx_data_o(tx_data_o), .tx_ctrl_o(tx_ctrl_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
        .link_up_o(link_up_o), .state_o(state_o), .retrain_cnt_o(retrain_cnt_o)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_i = 1'b1; tx_reset_done_i = 1'b0; rx_reset_done_i = 1'b0;
        rx_disp_err_i = 2'b00; rx_not_in_table_i = 2'b00;
        tx_valid_i = 1'b0; tx_data_i = 16'h0000;
        tick(2);
        chk("rst_state", state_o, 0);
        chk("rst_gt_reset", gt_reset_o, 1);
        chk("rst_tx_data", tx_data_o, 16'h50BC);
        chk("rst_tx_ctrl", tx_ctrl_o, 2'b01);
        chk("rst_rx_data", rx_data_o, 0);
        chk("rst_rx_valid", rx_valid_o, 0);
        chk("rst_link_up", link_up_o, 0);
        chk("rst_tx_ready", tx_ready_o, 0);
        chk("rst_retrain", retrain_cnt_o, 0);

        // Bring-up: 16 reset cycles, done at cycle 30, then 64 clean idles.
        rst_i = 1'b0;
        tick(15);
        chk("reset_hold_15", {state_o, gt_reset_o}, {2'd0, 1'b1});
        tick(1);
        chk("reset_release_16", {state_o, gt_reset_o}, {2'd1, 1'b0});
        tick(14);
        chk("wait_done_c30", state_o, 1);
        tx_reset_done_i = 1'b1; rx_reset_done_i = 1'b1;
        tick(1);
        chk("align_entry", state_o, 2);
        chk("align_tx_idle", {tx_ctrl_o, tx_data_o}, {2'b01, 16'h50BC});
        tick(63);
        chk("align_63", {state_o, link_up_o}, {2'd2, 1'b0});
        tick(1);
        chk("align_64_up", {state_o, link_up_o, tx_ready_o}, {2'd3, 1'b1, 1'b1});

        // Data path: edges counted from LINK_UP entry.
        tx_valid_i = 1'b1; tx_data_i = 16'hDEAD;
        tick(1);
        chk("tx_dead", {tx_ctrl_o, tx_data_o}, {2'b00, 16'hDEAD});
        tx_data_i = 16'hBEEF;
        tick(1);
        chk("tx_beef", {tx_ctrl_o, tx_data_o}, {2'b00, 16'hBEEF});
        chk("rx_dead", {rx_valid_o, rx_data_o}, {1'b1, 16'hDEAD});
        tx_valid_i = 1'b0;
        tick(1);
        chk("tx_idle_gap", {tx_ctrl_o, tx_data_o}, {2'b01, 16'h50BC});
        chk("rx_beef", {rx_valid_o, rx_data_o}, {1'b1, 16'hBEEF});
        tx_valid_i = 1'b1; tx_data_i = 16'h1234;
        tick(1);
        chk("rx_idle_filtered", {rx_valid_o, rx_data_o}, {1'b0, 16'hBEEF});
        tx_valid_i = 1'b0; rx_disp_err_i = 2'b01;
        tick(1);
        chk("rx_err_dropped", {rx_valid_o, rx_data_o}, {1'b0, 16'hBEEF});
        rx_disp_err_i = 2'b00;
        tick(1);
        chk("rx_idle_after_err", rx_valid_o, 0);

        // Error window: 1 error above + 13 more in window one, wrap-cycle error opens window two.
        tick(1004);
        rx_disp_err_i = 2'b10;
        tick(13);
        chk("errs_14_win1", state_o, 3);
        rx_disp_err_i = 2'b11; rx_not_in_table_i = 2'b11;
        tick(1);
        chk("err_on_wrap", state_o, 3);
        rx_disp_err_i = 2'b00; rx_not_in_table_i = 2'b01;
        tick(13);
        chk("errs_14_win2", {state_o, link_up_o}, {2'd3, 1'b1});
        tick(1);
        chk("errs_15_state", {state_o, gt_reset_o}, {2'd0, 1'b1});
        chk("errs_15_flags", {link_up_o, tx_ready_o, rx_valid_o}, 3'b000);
        chk("errs_15_retrain", retrain_cnt_o, 1);
        rx_not_in_table_i = 2'b00;

        // Retrain with one not-in-table word at run count 63.
        tick(16);
        chk("retrain_wait", state_o, 1);
        tick(1);
        chk("retrain_align", state_o, 2);
        tick(63);
        rx_not_in_table_i = 2'b01;
        tick(1);
        chk("nit_run_restart", {state_o, link_up_o}, {2'd2, 1'b0});
        rx_not_in_table_i = 2'b00;
        tick(63);
        chk("nit_63_more", state_o, 2);
        tick(1);
        chk("nit_64_more_up", {state_o, link_up_o}, {2'd3, 1'b1});

        // Loss of rx reset-done, then WAIT_DONE timeout with it held low.
        rx_reset_done_i = 1'b0;
        tick(1);
        chk("done_loss", {state_o, link_up_o}, {2'd0, 1'b0});
        chk("done_loss_retrain", retrain_cnt_o, 2);
        tick(16);
        chk("tmo_wait_entry", state_o, 1);
        tick(65535);
        chk("tmo_65535", {state_o, retrain_cnt_o}, {2'd1, 8'd2});
        tick(1);
        chk("tmo_65536", {state_o, gt_reset_o, retrain_cnt_o}, {2'd0, 1'b1, 8'd3});
        tick(16);
        chk("tmo_loops", state_o, 1);

        rst_i = 1'b1;
        tick(1);
        chk("rst_override", {state_o, retrain_cnt_o, gt_reset_o}, {2'd0, 8'd0, 1'b1});

        // Clock-correction slots under continuous tx_valid_i.
        rst_i = 1'b0; rx_reset_done_i = 1'b1;
        tick(17);
        tick(64);
        chk("cc_link_up", state_o, 3);
        tx_valid_i = 1'b1; tx_data_i = 16'hCAFE;
        tick(4998);
        chk("cc_before_slot", {tx_ready_o, tx_data_o}, {1'b1, 16'hCAFE});
        tick(1);
        chk("cc_slot1_ready", tx_ready_o, !CC_EN);
        tick(1);
        chk("cc_slot1_tx", {tx_ready_o, tx_ctrl_o, tx_data_o},
            CC_EN ? {1'b1, 2'b01, 16'h50BC} : {1'b1, 2'b00, 16'hCAFE});
        tick(1);
        chk("cc_after_slot", {tx_ctrl_o, tx_data_o}, {2'b00, 16'hCAFE});
        tick(4997);
        chk("cc_pre_slot2", tx_ready_o, 1);
        tick(1);
        chk("cc_slot2_ready", tx_ready_o, !CC_EN);
        tick(1);
        chk("cc_slot2_back", {tx_ready_o, link_up_o}, 2'b11);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
